// File: rtl/mem_access_unit_if.sv
// Request/response and memory-side bundle for mem_access_unit.
// The pipeline side and the memory model both connect through the master modport.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  req_ready;
  logic                  stall;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_misaligned;
  logic                  resp_bus_err;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, stall, resp_valid, resp_rdata, resp_misaligned, resp_bus_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, stall, resp_valid, resp_rdata, resp_misaligned, resp_bus_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: aligns pipeline byte/half/word/dword accesses onto a
// DATA_W-wide memory port, extends load data and reports alignment/timeout errors.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic [7:0]          cnt;
  logic                accept;
  logic                misaligned;
  logic                timeout_hit;

  logic                write_p0;
  logic                uns_p0;
  logic [1:0]          size_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;

  logic [DATA_W-1:0]   rdata_p1;
  logic                mis_p1;
  logic                berr_p1;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return low[0];
      2'd2:    return |low[1:0];
      default: return (DATA_W == 32) || (|low);
    endcase
  endfunction

  function automatic logic [LANES-1:0] be_mask(input logic [1:0] size,
                                               input logic [OFF_W-1:0] off);
    logic [LANES-1:0] base;
    case (size)
      2'd0:    base = LANES'(1);
      2'd1:    base = LANES'(3);
      2'd2:    base = LANES'(15);
      default: base = '1;
    endcase
    return base << off;
  endfunction

  // Replicate the low (8 << size) bits of the store data over the whole bus.
  function automatic logic [DATA_W-1:0] lane_fill(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] size);
    logic [DATA_W-1:0] r;
    int                w;
    w = 8 << size;
    if (w > DATA_W) w = DATA_W;
    for (int i = 0; i < DATA_W; i++) r[i] = d[i % w];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input int bits, input logic uns);
    logic signed [DATA_W-1:0] s;
    s = signed'(v << (DATA_W - bits));
    if (uns) return unsigned'(s) >> (DATA_W - bits);
    return unsigned'(s >>> (DATA_W - bits));
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [1:0] size,
                                                 input logic uns);
    logic [DATA_W-1:0] sh;
    int                bits;
    sh   = raw >> {off, 3'b000};
    bits = 8 << size;
    if (bits >= DATA_W) return sh;
    return extend(sh, bits, uns);
  endfunction

  assign accept      = bus.req_valid && (state == IDLE);
  assign misaligned  = is_misaligned(bus.req_size, bus.req_addr[2:0]);
  assign timeout_hit = !bus.mem_ack && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = misaligned ? RESP : ACCESS;
      ACCESS:  if (bus.mem_ack || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      mis_p1  <= 1'b0;
      berr_p1 <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      mis_p1  <= misaligned;
      berr_p1 <= 1'b0;
    end else if (state == ACCESS) begin
      if (!bus.mem_ack) cnt <= cnt + 8'd1;
      if (timeout_hit)  berr_p1 <= 1'b1;
    end
  end

  // p0: request latched at accept; p1: extended load data captured on mem_ack
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0 <= bus.req_write;
      uns_p0   <= bus.req_unsigned;
      size_p0  <= bus.req_size;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
    end
    if (state == ACCESS && bus.mem_ack)
      rdata_p1 <= write_p0 ? '0 : load_ext(bus.mem_rdata, addr_p0[OFF_W-1:0], size_p0, uns_p0);
  end

  always_comb begin
    bus.req_ready       = (state == IDLE);
    bus.stall           = reset && ((state == IDLE && bus.req_valid) || state == ACCESS);
    bus.resp_valid      = 1'b0;
    bus.resp_rdata      = '0;
    bus.resp_misaligned = 1'b0;
    bus.resp_bus_err    = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_be          = '0;
    bus.mem_wdata       = '0;
    case (state)
      ACCESS: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = write_p0;
        bus.mem_addr  = addr_p0 & ~ADDR_W'(LANES - 1);
        bus.mem_be    = be_mask(size_p0, addr_p0[OFF_W-1:0]);
        bus.mem_wdata = lane_fill(wdata_p0, size_p0);
      end
      RESP: begin
        bus.resp_valid      = 1'b1;
        bus.resp_misaligned = mis_p1;
        bus.resp_bus_err    = berr_p1;
        if (!mis_p1 && !berr_p1) bus.resp_rdata = rdata_p1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, data path width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles waiting for mem_ack; legal range 2..255.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; block is in reset while reset==0 at a rising edge of clk.
REQ-006 req_valid  in  1  pipeline memory request present.
REQ-007 req_write  in  1  1=store, 0=load.
REQ-008 req_size  in  2  0=byte, 1=half, 2=word, 3=dword (legal only if DATA_W==64).
REQ-009 req_unsigned  in  1  1=zero-extend load (LBU/LHU/LWU), 0=sign-extend.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  store data, right-aligned.
REQ-012 req_ready  out  1  high only in IDLE.
REQ-013 stall  out  1  pipeline hold request.
REQ-014 resp_valid  out  1  one-cycle completion pulse.
REQ-015 resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
REQ-016 resp_misaligned  out  1  alignment or size error, valid with resp_valid.
REQ-017 resp_bus_err  out  1  timeout error, valid with resp_valid.
REQ-018 mem_req / mem_we  out  1 / 1  memory request and write enable.
REQ-019 mem_addr  out  ADDR_W  req_addr with low log2(DATA_W/8) bits cleared.
REQ-020 mem_be  out  DATA_W/8  byte enables; bit i = byte lane i (little-endian).
REQ-021 mem_wdata  out  DATA_W  store data replicated across all lanes of the access size.
REQ-022 mem_ack  in  1  memory completion; mem_rdata  in  DATA_W  sampled when mem_ack==1.

Function
REQ-023 FSM states IDLE, ACCESS, RESP; request accepted when req_valid && req_ready.
REQ-024 On accept, address, size, write, unsigned and wdata are latched; later input changes have no effect.
REQ-025 Misaligned accept (half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0) or size 3 with DATA_W==32: IDLE->RESP, resp_misaligned=1, mem_req never asserted.
REQ-026 Legal accept: IDLE->ACCESS; mem_req=1 and all mem_* outputs held stable every ACCESS cycle.
REQ-027 ACCESS with mem_ack==1: capture mem_rdata, drop mem_req next cycle, ACCESS->RESP.
REQ-028 Timeout counter clears on entry to ACCESS and increments each ACCESS cycle without ack; on TIMEOUT-th ACK-less cycle ->RESP with resp_bus_err=1, mem_req dropped; ack on that same cycle wins (normal completion).
REQ-029 RESP lasts exactly one cycle, resp_valid=1, then ->IDLE; no back-to-back accept in RESP (req_ready=0).
REQ-030 stall = (state==IDLE && req_valid) || state==ACCESS; stall=0 in RESP.
REQ-031 Latency accept-to-resp_valid: 1 cycle for misaligned, N+1 cycles when mem_ack arrives in the N-th ACCESS cycle.
REQ-032 Load: select lane(s) at offset addr[log2(DATA_W/8)-1:0], extend to DATA_W per req_unsigned; word loads with DATA_W==32 ignore req_unsigned.
REQ-033 Store: mem_be has 1/2/4/8 contiguous ones starting at lane offset; resp_rdata=0.

Reset
REQ-034 While reset==0: state=IDLE, counter=0, all outputs 0 except req_ready=1; applies mid-ACCESS (mem_req drops at that edge, no resp_valid generated).

Verification
REQ-035 SB wdata 0xFF addr 0x10, then LB 0x10 -> 0xFFFFFFFF, LBU 0x10 -> 0x000000FF; SB mem_be=0001, mem_wdata=0xFFFFFFFF.
REQ-036 SH 0xCFC7 addr 0x22 -> mem_be=1100, mem_wdata=0xCFC7CFC7, mem_addr=0x20; LH 0x22 -> 0xFFFFCFC7, LHU -> 0x0000CFC7.
REQ-037 LW addr 0x13 -> resp_valid+resp_misaligned one cycle after accept, mem_req stays 0, resp_rdata=0.
REQ-038 TIMEOUT=8, LW 0x40 with mem_ack tied 0 -> mem_req high 8 cycles, then resp_bus_err=1; repeat with ack on cycle 8 -> normal data.
REQ-039 DATA_W=64: LWU addr 0x04 of word 0xFFFFFFFF -> 0x00000000FFFFFFFF; LW -> 0xFFFFFFFFFFFFFFFF; LD addr 0x04 -> misaligned.
REQ-040 reset=0 during ACCESS cycle 3 -> next edge mem_req=0, req_ready=1, no resp_valid; new LW after reset completes normally.
